// File: rtl/flag_bank.sv
// Bank of independent set/unset flags with edge pulses and any/all status.
// Optional per-flag watchdog auto-clear enabled by FLAG_BANK_TIMEOUT_EN.
module flag_bank #(
   parameter int unsigned           NFLAGS   = 4,
   parameter logic [NFLAGS-1:0]     SET_PRIO = {NFLAGS{1'b0}},
   parameter int unsigned           TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NFLAGS-1:0] syn_set,
   input  logic [NFLAGS-1:0] syn_unset,
   output logic [NFLAGS-1:0] flags,
   output logic [NFLAGS-1:0] rise,
   output logic [NFLAGS-1:0] fall,
   output logic              any,
   output logic              all,
   output logic [NFLAGS-1:0] timeout
);

   logic [NFLAGS-1:0] flags_nxt;
   logic [NFLAGS-1:0] timeout_nxt;

`ifdef FLAG_BANK_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q   [NFLAGS];
   logic [CW-1:0] cnt_nxt [NFLAGS];
`endif

   // Request resolution and watchdog expiry; explicit requests beat expiry
   always_comb begin
      flags_nxt   = flags;
      timeout_nxt = '0;
      for (int i = 0; i < int'(NFLAGS); i++) begin
`ifdef FLAG_BANK_TIMEOUT_EN
         cnt_nxt[i] = '0;
`endif
         if (syn_set[i] && syn_unset[i]) begin
            flags_nxt[i] = SET_PRIO[i];
         end else if (syn_set[i]) begin
            flags_nxt[i] = 1'b1;
         end else if (syn_unset[i]) begin
            flags_nxt[i] = 1'b0;
         end
`ifdef FLAG_BANK_TIMEOUT_EN
         else if (flags[i]) begin
            if (cnt_q[i] == CW'(TIMEOUT - 1)) begin
               flags_nxt[i]   = 1'b0;
               timeout_nxt[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt_q[i] + CW'(1);
            end
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flags   <= '0;
         rise    <= '0;
         fall    <= '0;
         timeout <= '0;
         any     <= 1'b0;
         all     <= 1'b0;
      end else begin
         flags   <= flags_nxt;
         rise    <= flags_nxt & ~flags;
         fall    <= ~flags_nxt & flags;
         timeout <= timeout_nxt;
         any     <= |flags_nxt;
         all     <= &flags_nxt;
      end
   end

`ifdef FLAG_BANK_TIMEOUT_EN
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(NFLAGS); i++) begin
         if (rst) cnt_q[i] <= '0;
         else     cnt_q[i] <= cnt_nxt[i];
      end
   end
`endif

endmodule

// File: tb/tb_flag_bank.sv
// Directed self-checking bench for flag_bank (NFLAGS=4, SET_PRIO=4'b0011, TIMEOUT=5).
module tb_flag_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] syn_set;
   logic [3:0] syn_unset;
   logic [3:0] flags, rise, fall, timeout;
   logic       any, all;

   int checks   = 0;
   int failures = 0;

   flag_bank #(
      .NFLAGS   (4),
      .SET_PRIO (4'b0011),
      .TIMEOUT  (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .syn_set   (syn_set),
      .syn_unset (syn_unset),
      .flags     (flags),
      .rise      (rise),
      .fall      (fall),
      .any       (any),
      .all       (all),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] f, input logic [3:0] r,
                            input logic [3:0] fl, input logic [3:0] t);
      check({tag, ".flags"},   32'(flags),   32'(f));
      check({tag, ".rise"},    32'(rise),    32'(r));
      check({tag, ".fall"},    32'(fall),    32'(fl));
      check({tag, ".timeout"}, 32'(timeout), 32'(t));
      check({tag, ".any"},     32'(any),     32'(|f));
      check({tag, ".all"},     32'(all),     32'(&f));
   endtask

   initial begin
      #200000;
      $display("FAIL sim_time_limit: got timeout expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst = 1'b1; syn_set = '0; syn_unset = '0;
      tick(); tick();
      check_all("reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      rst = 1'b0;
      repeat (10) tick();
      check_all("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Basic set and clear
      syn_set = 4'b0101; tick(); syn_set = '0;
      check_all("set0101", 4'b0101, 4'b0101, 4'b0000, 4'b0000);
      syn_unset = 4'b0001; tick(); syn_unset = '0;
      check_all("unset0001", 4'b0100, 4'b0000, 4'b0001, 4'b0000);
      syn_unset = 4'b1111; tick(); syn_unset = '0;
      check_all("unset_all", 4'b0000, 4'b0000, 4'b0100, 4'b0000);
      syn_unset = 4'b1111; tick(); syn_unset = '0;
      check_all("unset_clear", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Collisions resolved by SET_PRIO from clear and from set
      syn_set = 4'b1111; syn_unset = 4'b1111; tick();
      syn_set = 4'b1100; syn_unset = '0;
      check_all("collide_clear", 4'b0011, 4'b0011, 4'b0000, 4'b0000);
      tick();
      check_all("fill", 4'b1111, 4'b1100, 4'b0000, 4'b0000);
      syn_set = 4'b1111; syn_unset = 4'b1111; tick();
      syn_set = '0; syn_unset = 4'b1111;
      check_all("collide_set", 4'b0011, 4'b0000, 4'b1100, 4'b0000);
      tick(); syn_unset = '0;
      check_all("clear_again", 4'b0000, 4'b0000, 4'b0011, 4'b0000);

      // Reset mid-count, with a concurrent set request that must lose
      syn_set = 4'b1111; tick(); syn_set = '0;
      check_all("set_all", 4'b1111, 4'b1111, 4'b0000, 4'b0000);
      tick(); tick();
      rst = 1'b1; syn_set = 4'b1111; tick();
      rst = 1'b0; syn_set = '0;
      check_all("rst_mid", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

`ifdef FLAG_BANK_TIMEOUT_EN
      // Single set: high for exactly 5 cycles, then expiry with fall
      syn_set = 4'b0001; tick(); syn_set = '0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("wd_high%0d", i), 32'({flags[0], timeout[0]}), 32'(2'b10));
         tick();
      end
      check_all("wd_expire", 4'b0000, 4'b0000, 4'b0001, 4'b0001);
      tick();
      check_all("wd_after", 4'b0000, 4'b0000, 4'b0000, 4'b0000);

      // Re-set on cycle 3: high for 3 + 5 cycles
      syn_set = 4'b0001; tick(); syn_set = '0;
      check("reset3_c1", 32'(flags[0]), 32'd1); tick();
      check("reset3_c2", 32'(flags[0]), 32'd1); tick();
      check("reset3_c3", 32'(flags[0]), 32'd1);
      syn_set = 4'b0001; tick(); syn_set = '0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("reset3_tail%0d", i), 32'({flags[0], rise[0], timeout[0]}), 32'(3'b100));
         tick();
      end
      check_all("reset3_expire", 4'b0000, 4'b0000, 4'b0001, 4'b0001);

      // Unset in the expiry cycle: fall without timeout
      syn_set = 4'b0001; tick(); syn_set = '0;
      repeat (4) tick();
      check("exp_unset_pre", 32'(flags[0]), 32'd1);
      syn_unset = 4'b0001; tick(); syn_unset = '0;
      check_all("exp_unset", 4'b0000, 4'b0000, 4'b0001, 4'b0000);

      // Set in the expiry cycle: stays high, counter restarts
      syn_set = 4'b0001; tick(); syn_set = '0;
      repeat (4) tick();
      syn_set = 4'b0001; tick(); syn_set = '0;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("exp_set%0d", i), 32'({flags[0], rise[0], fall[0], timeout[0]}), 32'(4'b1000));
         tick();
      end
      check_all("exp_set_expire", 4'b0000, 4'b0000, 4'b0001, 4'b0001);
`else
      // Without the watchdog a set flag holds indefinitely
      syn_set = 4'b0001; tick(); syn_set = '0;
      for (int i = 0; i < 100; i++) begin
         if (i % 10 == 0)
            check($sformatf("hold%0d", i), 32'({flags, timeout}), 32'(8'b0001_0000));
         tick();
      end
      check_all("hold_end", 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      syn_unset = 4'b0001; tick(); syn_unset = '0;
      check_all("hold_clear", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flag_bank.md
# flag_bank

Parametrised bank of independent single-bit control flags for the mode controller. Each flag is set or cleared by synchronous one-cycle requests, with a per-flag policy that decides which request wins when both arrive together. The bank adds registered rise/fall event pulses and aggregate any/all status. An optional per-flag watchdog auto-clears a flag that stays set too long. It replaces ad-hoc single flags wherever the mode FSM tracks several status conditions at once.

## Interface
Parameters:
- NFLAGS, 4: number of flags; 1..32.
- SET_PRIO, {NFLAGS{1'b0}}: per-flag policy; bit i = 1 means set wins on simultaneous set/unset, 0 means unset wins.
- TIMEOUT, 16: watchdog period in cycles; 1..65535; used only with FLAG_BANK_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- syn_set  in  NFLAGS  per-flag set request, one-cycle qualified.
- syn_unset  in  NFLAGS  per-flag clear request, one-cycle qualified.
- flags  out  NFLAGS  registered flag values.
- rise  out  NFLAGS  registered pulse; bit i = 1 for the first cycle flags[i] is 1 after being 0.
- fall  out  NFLAGS  registered pulse; bit i = 1 for the first cycle flags[i] is 0 after being 1.
- any  out  1  registered OR of next flag values; equals |flags every cycle.
- all  out  1  registered AND; equals &flags every cycle.
- timeout  out  NFLAGS  registered pulse; bit i = 1 in the first cycle flags[i] is 0 because of watchdog expiry.

## Operation
- Per flag i, next value:
  - set only -> 1.
  - unset only -> 0.
  - both -> SET_PRIO[i].
  - neither -> hold, except watchdog expiry -> 0.
- A set on an already-set flag is legal. It keeps the flag at 1, produces no rise pulse, and restarts the watchdog.
- An unset on a clear flag is legal and produces no fall pulse.
- rise/fall/timeout are computed from next vs current value and registered alongside flags, so they are exactly aligned with the visible change.
- Watchdog (with the macro), counter cnt[i] of width clog2(TIMEOUT+1):
  - Cleared to 0 by any cycle where the resolved request sets flag i.
  - Increments each cycle flags[i]=1 with no request resolving on flag i.
  - When cnt[i] == TIMEOUT-1 under the increment condition, flag i clears next cycle and timeout[i] pulses together with fall[i].
  - An explicit request in the expiry cycle has precedence: a resolved set restarts the count; a resolved unset clears the flag with fall[i] but no timeout[i].
  - Counter is held at 0 while the flag is clear.
- Flags are fully independent; no cross-flag interaction except any/all.

## Timing
- Reset: flags=0, rise=0, fall=0, timeout=0, any=0, all=0, counters=0.
- rst has priority over all requests in the same cycle. Reset mid-count discards the count without raising a timeout pulse.
- Latency: request sampled at edge k, visible on flags after edge k (1 cycle). Pulses last exactly 1 cycle.
- Watchdog: a flag set by a request at edge k with no further requests reads 1 for exactly TIMEOUT cycles, then 0 with timeout pulse.
- No combinational path from inputs to outputs.

## Configuration
- FLAG_BANK_TIMEOUT_EN defined: watchdog counters and expiry logic compiled in as above.
- Not defined: no counters; flags hold until explicitly unset; timeout output tied to 0; TIMEOUT ignored.

## Test plan
- Reset then idle: NFLAGS=4, 10 cycles -> flags=4'b0000, any=0, all=0, no pulses.
- Set/clear: syn_set=4'b0101 one cycle -> next cycle flags=4'b0101, rise=4'b0101. Then syn_unset=4'b0001 -> flags=4'b0100, fall=4'b0001, any=1, all=0.
- Collision: SET_PRIO=4'b0011, syn_set=syn_unset=4'b1111 from all-clear -> flags=4'b0011, rise=4'b0011.
- Watchdog (macro on, TIMEOUT=5): set flag 0 once -> flags[0]=1 for 5 cycles, then 0 with timeout[0]=1 and fall[0]=1 in that same cycle. Re-set on cycle 3 of the count -> high for 3+5 cycles total.
- Expiry collision (macro on): unset in the expiry cycle -> fall[0]=1, timeout[0]=0. Set in the expiry cycle -> stays 1, counter restarts.
- Reset mid-count: flags=4'b1111, assert rst -> all outputs 0 next cycle, no timeout pulse. Macro off: flag held 100 cycles, timeout stays 0.
